// File: rtl/clk_ctrl.sv
// clk_ctrl: generates single-cycle clock-enable pulses for the picoMIPS core,
// either free-running through a prescaler or one per debounced button press.
module clk_ctrl #(
    parameter int unsigned DEBOUNCE_CYCLES = 50000
) (
    input  logic        fastclk,
    input  logic        reset,
    input  logic        mode_run,
    input  logic        step_btn,
    input  logic        halt,
    input  logic [1:0]  div_sel,
    output logic        clk_en,
    output logic [1:0]  state,
    output logic [15:0] cycle_cnt
);

    typedef enum logic [1:0] {
        StIdle   = 2'b00,
        StRun    = 2'b01,
        StStep   = 2'b10,
        StHalted = 2'b11
    } state_t;

    // Counter value reached on the last differing edge before deb flips.
    localparam logic [15:0] DebLast = 16'(DEBOUNCE_CYCLES - 1);

    state_t      state_q, state_d;
    logic        sync1_q, sync2_q;
    logic [15:0] deb_cnt_q, deb_cnt_d;
    logic        deb_q, deb_d;
    logic        press;
    logic [15:0] presc_q, presc_d, presc_last;
    logic [1:0]  div_sel_q;
    logic        presc_term, div_change;
    logic        clk_en_q, clk_en_d;
    logic [15:0] cycle_cnt_q;

    // Two-flop synchronizer for the asynchronous push-button.
    always_ff @(posedge fastclk) begin
        if (reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= step_btn;
            sync2_q <= sync1_q;
        end
    end

    // Debouncer: deb follows sync only after DEBOUNCE_CYCLES consecutive differing edges.
    always_comb begin
        deb_d     = deb_q;
        deb_cnt_d = '0;
        press     = 1'b0;
        if (sync2_q != deb_q) begin
            if (deb_cnt_q == DebLast) begin
                deb_d = sync2_q;
                press = sync2_q;
            end else begin
                deb_cnt_d = deb_cnt_q + 16'd1;
            end
        end
    end

    // Prescaler terminal value selected by div_sel.
    always_comb begin
        case (div_sel)
            2'b00:   presc_last = 16'd15;
            2'b01:   presc_last = 16'd255;
            2'b10:   presc_last = 16'd4095;
            default: presc_last = 16'hFFFF;
        endcase
    end

    assign presc_term = (presc_q == presc_last);
    assign div_change = (div_sel != div_sel_q);

    // Next-state, prescaler and enable-pulse decisions.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (mode_run) begin
                    state_d = StRun;
                end else if (press && !halt) begin
                    state_d = StStep;
                end
            end
            StRun: begin
                if (halt) begin
                    state_d = StHalted;
                end else if (!mode_run) begin
                    state_d = StIdle;
                end
            end
            StStep: state_d = StIdle;
            StHalted: begin
                if (!mode_run && !halt) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        // Prescaler only counts while staying in RUN; it is zero in every other state.
        if (state_d != StRun || state_q != StRun || div_change || presc_term) begin
            presc_d = '0;
        end else begin
            presc_d = presc_q + 16'd1;
        end

        clk_en_d = (state_q == StIdle && state_d == StStep) ||
                   (state_q == StRun && presc_term && !halt && mode_run);
    end

    // State, debounce, prescaler and pulse-count registers.
    always_ff @(posedge fastclk) begin
        if (reset) begin
            state_q     <= StIdle;
            deb_q       <= 1'b0;
            deb_cnt_q   <= '0;
            presc_q     <= '0;
            div_sel_q   <= '0;
            clk_en_q    <= 1'b0;
            cycle_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            deb_q     <= deb_d;
            deb_cnt_q <= deb_cnt_d;
            presc_q   <= presc_d;
            div_sel_q <= div_sel;
            clk_en_q  <= clk_en_d;
            if (clk_en_q && cycle_cnt_q != 16'hFFFF) begin
                cycle_cnt_q <= cycle_cnt_q + 16'd1;
            end
        end
    end

    assign state     = state_q;
    assign clk_en    = clk_en_q;
    assign cycle_cnt = cycle_cnt_q;

endmodule

// File: tb/tb_clk_ctrl.sv
// tb_clk_ctrl: directed stimulus for clk_ctrl with a behavioural reference model
// checked on every edge, plus hand-computed expectations at key points.
module tb_clk_ctrl;

    localparam int Deb = 4;

    logic        fastclk;
    logic        reset;
    logic        mode_run;
    logic        step_btn;
    logic        halt;
    logic [1:0]  div_sel;
    logic        clk_en;
    logic [1:0]  state;
    logic [15:0] cycle_cnt;

    clk_ctrl #(
        .DEBOUNCE_CYCLES(Deb)
    ) dut (
        .fastclk  (fastclk),
        .reset    (reset),
        .mode_run (mode_run),
        .step_btn (step_btn),
        .halt     (halt),
        .div_sel  (div_sel),
        .clk_en   (clk_en),
        .state    (state),
        .cycle_cnt(cycle_cnt)
    );

    initial fastclk = 1'b0;
    always #5 fastclk = ~fastclk;

    int n_chk;
    int n_pass;
    int edge_no;

    // Reference model state (state numbering follows the output encoding).
    int       m_state;
    bit       m_clk_en;
    int       m_pulses;
    bit       m_deb;
    bit       m_btnq[$];
    bit       m_win[$];
    int       m_ph;
    bit [1:0] m_prev_div;
    int       cnt_base;
    int       base_pulses;

    task automatic check(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s at edge %0d: got %0d, expected %0d", name, edge_no, act, exp);
        end
    endtask

    function automatic int exp_cnt();
        int v;
        v = cnt_base + m_pulses - base_pulses;
        return (v > 65535) ? 65535 : v;
    endfunction

    // One fastclk edge of the specified behaviour, using the inputs present at that edge.
    task automatic model_step();
        bit syn, press, all_diff, term, pulse;
        int nxt, n_cur, n_prev, presc;
        if (reset) begin
            m_state    = 0;
            m_clk_en   = 1'b0;
            m_pulses   = 0;
            m_deb      = 1'b0;
            m_btnq     = '{1'b0, 1'b0};
            m_win.delete();
            m_ph       = 0;
            m_prev_div = 2'b00;
            return;
        end
        if (m_clk_en) m_pulses++;

        // Synchronized button seen now is the raw level sampled two edges ago.
        syn = m_btnq[0];
        void'(m_btnq.pop_front());
        m_btnq.push_back(step_btn);

        press = 1'b0;
        m_win.push_back(syn);
        if (m_win.size() > Deb) void'(m_win.pop_front());
        all_diff = (m_win.size() == Deb);
        foreach (m_win[i]) if (m_win[i] == m_deb) all_diff = 1'b0;
        if (all_diff) begin
            m_deb = ~m_deb;
            press = m_deb;
            m_win.delete();
        end

        n_cur  = 16 << (4 * int'(div_sel));
        n_prev = 16 << (4 * int'(m_prev_div));
        presc  = m_ph % n_prev;
        term   = (m_state == 1) && (presc == n_cur - 1);

        nxt = m_state;
        case (m_state)
            0: if (mode_run) nxt = 1; else if (press && !halt) nxt = 2;
            1: if (halt) nxt = 3; else if (!mode_run) nxt = 0;
            2: nxt = 0;
            default: if (!mode_run && !halt) nxt = 0;
        endcase

        pulse = (m_state == 0 && nxt == 2) || (m_state == 1 && term && !halt && mode_run);
        if (nxt == 1 && m_state == 1 && div_sel == m_prev_div) m_ph++;
        else m_ph = 0;

        m_prev_div = div_sel;
        m_state    = nxt;
        m_clk_en   = pulse;
    endtask

    task automatic tick();
        @(posedge fastclk);
        model_step();
        edge_no++;
        #1;
        check("state", int'(state), m_state);
        check("clk_en", int'(clk_en), int'(m_clk_en));
        check("cycle_cnt", int'(cycle_cnt), exp_cnt());
    endtask

    initial begin
        n_chk = 0; n_pass = 0; edge_no = 0;
        m_state = 0; m_clk_en = 0; m_pulses = 0; m_deb = 0; m_ph = 0; m_prev_div = 0;
        m_btnq = '{1'b0, 1'b0};
        cnt_base = 0; base_pulses = 0;
        reset = 1'b1; mode_run = 1'b0; step_btn = 1'b0; halt = 1'b0; div_sel = 2'b00;

        // Reset held two edges with inputs toggling.
        for (int i = 0; i < 2; i++) begin
            mode_run = (i == 0); step_btn = (i == 0); halt = (i != 0);
            div_sel  = 2'(i + 1);
            tick();
            check("rst_state", int'(state), 0);
            check("rst_clk_en", int'(clk_en), 0);
            check("rst_cnt", int'(cycle_cnt), 0);
        end
        reset = 1'b0; mode_run = 1'b0; step_btn = 1'b0; halt = 1'b0; div_sel = 2'b00;
        tick();
        check("post_rst_state", int'(state), 0);
        check("post_rst_clk_en", int'(clk_en), 0);
        check("post_rst_cnt", int'(cycle_cnt), 0);
        repeat (2) tick();

        // Single step: button high from before e0.
        step_btn = 1'b1;
        for (int e = 0; e <= 6; e++) begin
            tick();
            if (e == 4) check("step_e4_state", int'(state), 0);
            if (e == 5) begin
                check("step_e5_state", int'(state), 2);
                check("step_e5_clk_en", int'(clk_en), 1);
            end
            if (e == 6) begin
                check("step_e6_state", int'(state), 0);
                check("step_e6_clk_en", int'(clk_en), 0);
                check("step_e6_cnt", int'(cycle_cnt), 1);
            end
        end
        step_btn = 1'b0;
        repeat (8) tick();
        check("release_cnt", int'(cycle_cnt), 1);

        // Bounce: toggle every two edges, then hold, then release.
        for (int i = 0; i < 20; i++) begin
            step_btn = ((i / 2) % 2 == 0);
            tick();
        end
        check("bounce_cnt", int'(cycle_cnt), 1);
        step_btn = 1'b1;
        repeat (10) tick();
        check("bounce_hold_cnt", int'(cycle_cnt), 2);
        step_btn = 1'b0;
        repeat (10) tick();
        check("bounce_release_cnt", int'(cycle_cnt), 2);

        // Free run at /16.
        mode_run = 1'b1; div_sel = 2'b00;
        tick();
        check("run_entry_state", int'(state), 1);
        for (int k = 1; k <= 100; k++) begin
            tick();
            check("run16_pulse", int'(clk_en), int'(k % 16 == 0));
        end

        // Divider change mid-count restarts the prescaler.
        div_sel = 2'b01;
        for (int j = 0; j <= 257; j++) begin
            tick();
            check("div256_pulse", int'(clk_en), int'(j == 256));
        end

        // Halt on a terminal edge.
        div_sel = 2'b00;
        tick();
        for (int j = 1; j <= 15; j++) tick();
        halt = 1'b1;
        tick();
        check("halt_state", int'(state), 3);
        check("halt_clk_en", int'(clk_en), 0);

        // Press while halted is ignored.
        step_btn = 1'b1;
        repeat (10) tick();
        check("halted_press_state", int'(state), 3);
        check("halted_press_cnt", int'(cycle_cnt), 9);
        mode_run = 1'b0; halt = 1'b0;
        tick();
        check("unhalt_state", int'(state), 0);
        repeat (4) tick();
        check("unhalt_idle_state", int'(state), 0);
        check("unhalt_idle_cnt", int'(cycle_cnt), 9);
        step_btn = 1'b0;
        repeat (8) tick();

        // Press during RUN is discarded.
        mode_run = 1'b1;
        tick();
        step_btn = 1'b1;
        repeat (8) tick();
        mode_run = 1'b0;
        tick();
        repeat (4) tick();
        check("run_press_state", int'(state), 0);
        check("run_press_cnt", int'(cycle_cnt), 9);
        step_btn = 1'b0;
        repeat (8) tick();

        // Saturation: preload the counter near its limit while idle.
        force dut.cycle_cnt_q = 16'hFFFC;
        #1;
        release dut.cycle_cnt_q;
        cnt_base = 32'hFFFC; base_pulses = m_pulses;
        tick();
        check("preload_cnt", int'(cycle_cnt), 32'hFFFC);
        mode_run = 1'b1;
        tick();
        for (int k = 1; k <= 100; k++) begin
            tick();
            check("sat_pulse", int'(clk_en), int'(k % 16 == 0));
        end
        check("sat_cnt", int'(cycle_cnt), 32'hFFFF);

        // Reset in the middle of a run.
        reset = 1'b1; cnt_base = 0; base_pulses = 0;
        tick();
        check("midrst_state", int'(state), 0);
        check("midrst_cnt", int'(cycle_cnt), 0);
        reset = 1'b0; mode_run = 1'b0;
        tick();
        check("after_midrst_state", int'(state), 0);
        check("after_midrst_clk_en", int'(clk_en), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
